// File: rtl/pl_reg_pkg.sv
// pl_reg_pkg: register-mode encoding and word-address helpers shared by the
// PS-PL register bank.
package pl_reg_pkg;

    typedef enum logic [1:0] {
        RW    = 2'd0,
        RO    = 2'd1,
        PULSE = 2'd2,
        W1C   = 2'd3
    } reg_mode_e;

    function automatic int unsigned addr_lsb(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic logic [31:0] word_idx(input logic [31:0] addr, input int unsigned lsb);
        return addr >> lsb;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous status inputs.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pl_reg_bank.sv
// pl_reg_bank: PS-PL register file with per-register RW / RO / PULSE / W1C
// behaviour, byte-strobed writes, one-cycle registered reads and a level irq.
module pl_reg_bank
    import pl_reg_pkg::*;
#(
    parameter int                            DATA_WIDTH = 32,
    parameter int                            NUM_REGS   = 32,
    parameter int                            ADDR_WIDTH = 10,
    parameter logic [2*NUM_REGS-1:0]         MODE       = '0,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RST_VAL   = '0
) (
    input  logic                           ps_clk,
    input  logic                           ps_rstn,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic [DATA_WIDTH/8-1:0]        wr_strb,
    input  logic                           rd_en,
    input  logic [ADDR_WIDTH-1:0]          rd_addr,
    output logic [DATA_WIDTH-1:0]          rd_data,
    output logic                           rd_valid,
    output logic                           rd_err,
    output logic [NUM_REGS*DATA_WIDTH-1:0] ctrl_out,
    output logic [NUM_REGS*DATA_WIDTH-1:0] pulse_out,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in,
    output logic                           irq
);

    localparam int          NB       = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB = addr_lsb(DATA_WIDTH);
    localparam int          IW       = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;

    logic [NUM_REGS*DATA_WIDTH-1:0] status_sync;
    logic [NUM_REGS*DATA_WIDTH-1:0] w1c_all;
    logic [DATA_WIDTH-1:0]          wmask;
    logic [DATA_WIDTH-1:0]          wbits;
    logic [DATA_WIDTH-1:0]          word_val [NUM_REGS];
    logic [31:0]                    wr_idx;
    logic [31:0]                    rd_idx;
    logic                           rd_ok;
    logic                           unused_ok;

    sync_2ff #(.WIDTH(NUM_REGS * DATA_WIDTH)) u_sync (
        .clk  (ps_clk),
        .rst_n(ps_rstn),
        .d    (status_in),
        .q    (status_sync)
    );

    assign wr_idx    = word_idx(32'(wr_addr), ADDR_LSB);
    assign rd_idx    = word_idx(32'(rd_addr), ADDR_LSB);
    assign rd_ok     = rd_idx < 32'(NUM_REGS);
    assign wbits     = wr_data & wmask;
    assign unused_ok = ^{wr_idx, rd_idx, status_sync};

    for (genvar b = 0; b < NB; b++) begin : g_mask
        assign wmask[8*b +: 8] = {8{wr_strb[b]}};
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        localparam reg_mode_e M  = reg_mode_e'(MODE[2*r +: 2]);
        localparam int        LO = r * DATA_WIDTH;
        logic hit;
        assign hit = wr_en && wr_idx == 32'(r);
        if (M == RW) begin : g_rw
            logic [DATA_WIDTH-1:0] q;
            always_ff @(posedge ps_clk or negedge ps_rstn) begin
                if (!ps_rstn) q <= RST_VAL[LO +: DATA_WIDTH];
                else if (hit) q <= (q & ~wmask) | wbits;
            end
            assign word_val[r]                = q;
            assign ctrl_out[LO +: DATA_WIDTH]  = q;
            assign pulse_out[LO +: DATA_WIDTH] = '0;
            assign w1c_all[LO +: DATA_WIDTH]   = '0;
        end else if (M == RO) begin : g_ro
            assign word_val[r]                = status_sync[LO +: DATA_WIDTH];
            assign ctrl_out[LO +: DATA_WIDTH]  = '0;
            assign pulse_out[LO +: DATA_WIDTH] = '0;
            assign w1c_all[LO +: DATA_WIDTH]   = '0;
        end else if (M == PULSE) begin : g_pulse
            logic [DATA_WIDTH-1:0] p;
            always_ff @(posedge ps_clk or negedge ps_rstn) begin
                if (!ps_rstn) p <= '0;
                else p <= hit ? wbits : '0;
            end
            assign word_val[r]                = '0;
            assign ctrl_out[LO +: DATA_WIDTH]  = '0;
            assign pulse_out[LO +: DATA_WIDTH] = p;
            assign w1c_all[LO +: DATA_WIDTH]   = '0;
        end else begin : g_w1c
            logic [DATA_WIDTH-1:0] q;
            logic [DATA_WIDTH-1:0] prev;
            // set is OR-ed in after the clear so a same-cycle event wins
            always_ff @(posedge ps_clk or negedge ps_rstn) begin
                if (!ps_rstn) begin
                    q    <= '0;
                    prev <= '0;
                end else begin
                    prev <= status_sync[LO +: DATA_WIDTH];
                    q    <= (q & ~(hit ? wbits : '0)) | (status_sync[LO +: DATA_WIDTH] & ~prev);
                end
            end
            assign word_val[r]                = q;
            assign ctrl_out[LO +: DATA_WIDTH]  = '0;
            assign pulse_out[LO +: DATA_WIDTH] = '0;
            assign w1c_all[LO +: DATA_WIDTH]   = q;
        end
    end

    always_ff @(posedge ps_clk or negedge ps_rstn) begin
        if (!ps_rstn) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            irq      <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_err   <= rd_en && !rd_ok;
            rd_data  <= rd_en && rd_ok ? word_val[rd_idx[IW-1:0]] : '0;
            irq      <= |w1c_all;
        end
    end

endmodule

// File: tb/tb_pl_reg_bank.sv
// tb_pl_reg_bank: directed self-checking bench for pl_reg_bank
// (reg0-2 RW, reg3 RO, reg5 PULSE, reg7 W1C, remaining RW).
module tb_pl_reg_bank;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 10;
    localparam logic [2*NR-1:0] MODE_P = (64'(1) << 6) | (64'(2) << 10) | (64'(3) << 14);
    localparam logic [NR*DW-1:0] RST_P = (1024'(32'hCAFEF00D) << 64) |
                                         (1024'(32'h12345678) << 32) |
                                          1024'(32'hDEADBEEF);

    logic             ps_clk = 1'b0;
    logic             ps_rstn;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic [DW/8-1:0]  wr_strb;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [DW-1:0]    rd_data;
    logic             rd_valid;
    logic             rd_err;
    logic [NR*DW-1:0] ctrl_out;
    logic [NR*DW-1:0] pulse_out;
    logic [NR*DW-1:0] status_in;
    logic             irq;

    int n_chk  = 0;
    int n_fail = 0;
    logic [DW-1:0] rv;

    pl_reg_bank #(
        .DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .MODE(MODE_P), .RST_VAL(RST_P)
    ) dut (
        .ps_clk   (ps_clk),
        .ps_rstn  (ps_rstn),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_strb  (wr_strb),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_err   (rd_err),
        .ctrl_out (ctrl_out),
        .pulse_out(pulse_out),
        .status_in(status_in),
        .irq      (irq)
    );

    always #5 ps_clk = ~ps_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ps_clk);
        #1;
    endtask

    function automatic logic [31:0] ctrl(input int r);
        return ctrl_out[r*DW +: DW];
    endfunction

    function automatic logic [31:0] pulse(input int r);
        return pulse_out[r*DW +: DW];
    endfunction

    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_strb = s;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic exp_err, input string tag);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        rv = rd_data;
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check({tag, "_err"}, 32'(rd_err), 32'(exp_err));
    endtask

    initial begin
        ps_rstn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0;
        rd_en = 1'b0; rd_addr = '0; status_in = '0;
        repeat (3) tick();
        ps_rstn = 1'b1;
        tick();

        check("rst_ctrl0", ctrl(0), 32'hDEADBEEF);
        check("rst_ctrl2", ctrl(2), 32'hCAFEF00D);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        do_read(10'h000, 1'b0, "rd_reg0");
        check("rd_reg0_data", rv, 32'hDEADBEEF);
        tick();
        check("rd_valid_one_cycle", 32'(rd_valid), 32'd0);

        do_write(10'h008, 32'h11223344, 4'b0101);
        check("strb_ctrl2", ctrl(2), 32'hCA22F044);
        do_read(10'h00B, 1'b0, "rd_reg2_offset");
        check("rd_reg2_data", rv, 32'hCA22F044);
        check("ctrl_pulse_reg_zero", ctrl(5), 32'd0);
        check("ctrl_ro_reg_zero", ctrl(3), 32'd0);

        do_write(10'h014, 32'h00000005, 4'hF);
        check("pulse_high", pulse(5), 32'h5);
        tick();
        check("pulse_low", pulse(5), 32'h0);
        do_write(10'h014, 32'hAABBCCDD, 4'b0010);
        check("pulse_strb", pulse(5), 32'h0000CC00);
        do_read(10'h014, 1'b0, "rd_pulse");
        check("rd_pulse_data", rv, 32'd0);
        check("pulse_after_read", pulse(5), 32'h0);

        status_in[3*DW +: DW] = 32'h0BADCAFE;
        tick();
        do_read(10'h00C, 1'b0, "rd_ro_early");
        check("rd_ro_early_data", rv, 32'd0);
        do_read(10'h00C, 1'b0, "rd_ro");
        check("rd_ro_data", rv, 32'h0BADCAFE);

        status_in[7*DW + 3] = 1'b1;
        repeat (3) tick();
        check("w1c_irq_at3", 32'(irq), 32'd0);
        tick();
        check("w1c_irq_at4", 32'(irq), 32'd1);
        do_read(10'h01C, 1'b0, "rd_w1c_set");
        check("rd_w1c_set_data", rv, 32'h8);

        status_in[7*DW + 3] = 1'b0;
        repeat (4) tick();
        status_in[7*DW + 3] = 1'b1;
        repeat (2) tick();
        do_write(10'h01C, 32'h8, 4'hF);
        do_read(10'h01C, 1'b0, "rd_w1c_setwins");
        check("rd_w1c_setwins_data", rv, 32'h8);
        check("irq_setwins", 32'(irq), 32'd1);

        do_write(10'h01C, 32'h8, 4'hF);
        check("irq_after_clear_n1", 32'(irq), 32'd1);
        do_read(10'h01C, 1'b0, "rd_w1c_clr");
        check("rd_w1c_clr_data", rv, 32'd0);
        check("irq_after_clear_n2", 32'(irq), 32'd0);

        do_read(10'h080, 1'b1, "rd_oor");
        check("rd_oor_data", rv, 32'd0);
        do_write(10'h080, 32'hFFFFFFFF, 4'hF);
        check("oor_ctrl0", ctrl(0), 32'hDEADBEEF);
        check("oor_ctrl1", ctrl(1), 32'h12345678);
        check("oor_ctrl2", ctrl(2), 32'hCA22F044);
        check("oor_pulse", 32'(|pulse_out), 32'd0);

        rd_en = 1'b1; rd_addr = 10'h004;
        wr_en = 1'b1; wr_addr = 10'h004; wr_data = 32'hA5A5A5A5; wr_strb = 4'hF;
        tick();
        rd_en = 1'b0; wr_en = 1'b0;
        check("coll_rd_data", rd_data, 32'h12345678);
        check("coll_ctrl1", ctrl(1), 32'hA5A5A5A5);

        do_write(10'h01C, 32'h0, 4'h0);
        rd_en = 1'b1; rd_addr = 10'h000;
        @(negedge ps_clk);
        ps_rstn = 1'b0;
        #1;
        check("rst_mid_valid", 32'(rd_valid), 32'd0);
        check("rst_mid_ctrl1", ctrl(1), 32'h12345678);
        check("rst_mid_ctrl2", ctrl(2), 32'hCAFEF00D);
        check("rst_mid_data", rd_data, 32'd0);
        check("rst_mid_irq", 32'(irq), 32'd0);
        tick();
        check("rst_hold_valid", 32'(rd_valid), 32'd0);
        rd_en = 1'b0;
        ps_rstn = 1'b1;
        repeat (3) tick();
        check("rst_status_high_irq3", 32'(irq), 32'd0);
        tick();
        check("rst_status_high_irq4", 32'(irq), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
